// File: rtl/cv32e40p_tmr_voter_monitor.sv
// TMR voter with per-replica fault tracking, optional duplex degradation and a sticky FAILED state.
// Define CV32E40P_TMR_DEGRADE_EN to build the DEGRADED (duplex-compare) mode.
module cv32e40p_tmr_voter_monitor #(
  parameter int DATA_WIDTH = 32,
  parameter int THRESHOLD  = 3,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic                  clear_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [DATA_WIDTH-1:0] c_i,
  output logic [DATA_WIDTH-1:0] winner_o,
  output logic                  fault_o,
  output logic [2:0]            replica_err_o,
  output logic [1:0]            mode_o,
  output logic                  uncorrectable_o,
  output logic [CNT_WIDTH-1:0]  fault_cnt_o
);

  localparam int CW = $clog2(THRESHOLD + 1);
  localparam logic [CW-1:0] THR = CW'(THRESHOLD);

  typedef enum logic [1:0] {
    MODE_TMR      = 2'd0,
    MODE_DEGRADED = 2'd1,
    MODE_FAILED   = 2'd2
  } mode_e;

  mode_e                state_q, state_d;
  logic [CW-1:0]        cnt_q [3];
  logic [CW-1:0]        cnt_d [3];
  logic [CW-1:0]        cnt_inc [3];
  logic [2:0]           err_q, err_d;
  logic [CNT_WIDTH-1:0] fcnt_q, fcnt_d;
`ifdef CV32E40P_TMR_DEGRADE_EN
  logic [1:0]           excl_q, excl_d;
  logic                 pair_differ;
`endif

  logic                  eq_ab, eq_ac, eq_bc, no_maj, found;
  logic [2:0]            odd, hit;
  logic [DATA_WIDTH-1:0] maj;

  assign eq_ab  = (a_i == b_i);
  assign eq_ac  = (a_i == c_i);
  assign eq_bc  = (b_i == c_i);
  assign odd[0] = eq_bc & ~eq_ab;
  assign odd[1] = eq_ac & ~eq_ab;
  assign odd[2] = eq_ab & ~eq_ac;
  assign no_maj = ~eq_ab & ~eq_ac & ~eq_bc;
  assign maj    = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

  assign fault_o         = valid_i & ~(eq_ab & eq_bc);
  assign replica_err_o   = err_q;
  assign mode_o          = state_q;
  assign uncorrectable_o = (state_q == MODE_FAILED);
  assign fault_cnt_o     = fcnt_q;

  always_comb begin
    winner_o = maj;
`ifdef CV32E40P_TMR_DEGRADE_EN
    if (state_q == MODE_DEGRADED) winner_o = (excl_q == 2'd0) ? b_i : a_i;
    case (excl_q)
      2'd0:    pair_differ = ~eq_bc;
      2'd1:    pair_differ = ~eq_ac;
      default: pair_differ = ~eq_ab;
    endcase
`endif
  end

  // Saturating increment; hit flags a counter landing on THRESHOLD this cycle.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cnt_inc[i] = (cnt_q[i] == THR) ? THR : cnt_q[i] + CW'(1);
      hit[i]     = valid_i & odd[i] & (cnt_inc[i] == THR);
    end
  end

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves one unassigned (no latches).
    state_d = state_q;
    err_d   = err_q;
    fcnt_d  = fcnt_q;
    cnt_d   = cnt_q;
    found   = 1'b0;
`ifdef CV32E40P_TMR_DEGRADE_EN
    excl_d  = excl_q;
`endif
    if (clear_i) begin
      state_d = MODE_TMR;
      err_d   = '0;
      fcnt_d  = '0;
      for (int i = 0; i < 3; i++) cnt_d[i] = '0;
`ifdef CV32E40P_TMR_DEGRADE_EN
      excl_d  = '0;
`endif
    end else begin
      if (fault_o && (fcnt_q != '1)) fcnt_d = fcnt_q + CNT_WIDTH'(1);
      if (valid_i) begin
        for (int i = 0; i < 3; i++) begin
`ifdef CV32E40P_TMR_DEGRADE_EN
          if (!(state_q == MODE_DEGRADED && excl_q == 2'(i))) begin
`else
          begin
`endif
            if (odd[i])       cnt_d[i] = cnt_inc[i];
            else if (!no_maj) cnt_d[i] = '0;
          end
        end
        case (state_q)
          MODE_TMR: begin
            if (no_maj) begin
              state_d = MODE_FAILED;
            end else begin
              for (int i = 0; i < 3; i++) begin
                if (hit[i] && !found) begin
                  found    = 1'b1;
                  err_d[i] = 1'b1;
`ifdef CV32E40P_TMR_DEGRADE_EN
                  state_d  = MODE_DEGRADED;
                  excl_d   = 2'(i);
`endif
                end
              end
            end
          end
`ifdef CV32E40P_TMR_DEGRADE_EN
          MODE_DEGRADED: if (pair_differ) state_d = MODE_FAILED;
`endif
          default: ;
        endcase
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MODE_TMR;
      err_q   <= '0;
      fcnt_q  <= '0;
      // NOTE: the counter array is tiny and must be reset so history never survives rst.
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
`ifdef CV32E40P_TMR_DEGRADE_EN
      excl_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      fcnt_q  <= fcnt_d;
      cnt_q   <= cnt_d;
`ifdef CV32E40P_TMR_DEGRADE_EN
      excl_q  <= excl_d;
`endif
    end
  end

endmodule

// File: tb/tb_cv32e40p_tmr_voter_monitor.sv
// Directed bench for cv32e40p_tmr_voter_monitor (default parameters; expectations follow the degrade macro).
module tb_cv32e40p_tmr_voter_monitor;

`ifdef CV32E40P_TMR_DEGRADE_EN
  localparam logic [1:0] DEG_MODE = 2'd1;
  localparam logic [1:0] DEG_FAIL = 2'd2;
  localparam logic       DEG_UNC  = 1'b1;
`else
  localparam logic [1:0] DEG_MODE = 2'd0;
  localparam logic [1:0] DEG_FAIL = 2'd0;
  localparam logic       DEG_UNC  = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, valid_i, clear_i;
  logic [31:0] a_i, b_i, c_i, winner_o;
  logic        fault_o, uncorrectable_o;
  logic [2:0]  replica_err_o;
  logic [1:0]  mode_o;
  logic [7:0]  fault_cnt_o;

  int tests = 0;
  int fails = 0;

  cv32e40p_tmr_voter_monitor dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .clear_i(clear_i),
    .a_i(a_i), .b_i(b_i), .c_i(c_i),
    .winner_o(winner_o), .fault_o(fault_o), .replica_err_o(replica_err_o),
    .mode_o(mode_o), .uncorrectable_o(uncorrectable_o), .fault_cnt_o(fault_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; combinational checks follow 1 unit later.
  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    valid_i = v; a_i = a; b_i = b; c_i = c;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".mode"}, 64'(mode_o), 64'd0);
    check({tag, ".err"}, 64'(replica_err_o), 64'd0);
    check({tag, ".unc"}, 64'(uncorrectable_o), 64'd0);
    check({tag, ".fcnt"}, 64'(fault_cnt_o), 64'd0);
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    drive(1'b1, 32'h0, 32'h0, 32'h0);
    tick();
    clear_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clear_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    tick(); tick();
    rst = 1'b0;
    check_idle("reset");

    // All replicas agree
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678);
      check("agree.winner", 64'(winner_o), 64'h1234_5678);
      check("agree.fault", 64'(fault_o), 64'd0);
      tick();
    end
    check_idle("agree");

    // b odd twice, agreement resets its counter, b odd twice more
    for (int i = 0; i < 5; i++) begin
      if (i == 2) drive(1'b1, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_FFFF);
      else        drive(1'b1, 32'h0000_FFFF, 32'hFFFF_0000, 32'h0000_FFFF);
      check("bodd.winner", 64'(winner_o), 64'h0000_FFFF);
      check("bodd.fault", 64'(fault_o), (i == 2) ? 64'd0 : 64'd1);
      tick();
    end
    check("bodd.fcnt", 64'(fault_cnt_o), 64'd4);
    check("bodd.err", 64'(replica_err_o), 64'd0);
    check("bodd.mode", 64'(mode_o), 64'd0);

    // Clear with a faulty sample: fault_o stays live, sample ignored
    clear_i = 1'b1;
    drive(1'b1, 32'h0000_FFFF, 32'hFFFF_0000, 32'h0000_FFFF);
    check("clr.fault", 64'(fault_o), 64'd1);
    tick();
    clear_i = 1'b0;
    check_idle("clr");

    // b odd three times hits THRESHOLD
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h0000_FFFF, 32'hFFFF_0000, 32'h0000_FFFF);
      check("thr.winner", 64'(winner_o), 64'h0000_FFFF);
      if (i < 2) check("thr.pre_err", 64'(replica_err_o), 64'd0);
      tick();
    end
    check("thr.err", 64'(replica_err_o), 64'b010);
    check("thr.mode", 64'(mode_o), 64'(DEG_MODE));
    drive(1'b1, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 32'hA5A5_A5A5);
    check("deg.winner", 64'(winner_o), 64'hA5A5_A5A5);
    tick();
    check("deg.mode", 64'(mode_o), 64'(DEG_MODE));
    // Healthy pair a/c disagree; winner is a in either build
    drive(1'b1, 32'h1, 32'h1, 32'h2);
    check("deg.split_winner", 64'(winner_o), 64'h1);
    tick();
    check("deg.split_mode", 64'(mode_o), 64'(DEG_FAIL));
    check("deg.split_unc", 64'(uncorrectable_o), 64'(DEG_UNC));
    check("deg.fcnt", 64'(fault_cnt_o), 64'd5);
    do_clear();
    check_idle("deg_clr");

    // valid_i low must not advance the per-replica counter
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h7, 32'h9, 32'h7);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 32'h7, 32'h9, 32'h7);
      if (i == 0) check("vlow.fault", 64'(fault_o), 64'd0);
      tick();
    end
    check("vlow.err", 64'(replica_err_o), 64'd0);
    check("vlow.fcnt", 64'(fault_cnt_o), 64'd2);
    drive(1'b1, 32'h7, 32'h9, 32'h7);
    tick();
    check("vlow.err_after", 64'(replica_err_o), 64'b010);
    do_clear();

    // No majority in TMR
    drive(1'b1, 32'h1, 32'h2, 32'h4);
    check("nomaj.winner", 64'(winner_o), 64'h0);
    check("nomaj.fault", 64'(fault_o), 64'd1);
    tick();
    check("nomaj.mode", 64'(mode_o), 64'd2);
    check("nomaj.unc", 64'(uncorrectable_o), 64'd1);
    drive(1'b0, 32'h3, 32'h5, 32'h6);
    check("failed.vlow_fault", 64'(fault_o), 64'd0);
    check("failed.winner", 64'(winner_o), 64'h7);
    tick();
    check("failed.fcnt", 64'(fault_cnt_o), 64'd1);
    check("failed.mode", 64'(mode_o), 64'd2);
    do_clear();
    check_idle("fail_clr");

    // Saturation of the total-fault counter
    drive(1'b1, 32'h1, 32'h2, 32'h4);
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 254) check("sat.254", 64'(fault_cnt_o), 64'd254);
      if (i == 255) check("sat.255", 64'(fault_cnt_o), 64'd255);
    end
    check("sat.300", 64'(fault_cnt_o), 64'd255);

    // Reset mid-stream
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("midrst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cv32e40p_tmr_voter_monitor.md
# cv32e40p_tmr_voter_monitor

Parametrised triple-modular-redundancy voter with fault tracking and graceful degradation. It replaces the stateless per-signal 3-way voters at the outputs of replicated execution units such as the triplicated ALU. It votes each valid sample and counts consecutive odd-one-out mismatches per replica. After a threshold it excludes a persistently faulty replica and continues in duplex-compare mode, escalating to a sticky uncorrectable state when no trustworthy majority remains.

## Interface

Parameters:
- DATA_WIDTH, 32: width of each replica word.
- THRESHOLD, 3: consecutive odd-one-out mismatches that condemn a replica; legal range 1..255.
- CNT_WIDTH, 8: width of the saturating total-fault counter.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- valid_i, input, 1: samples are meaningful this cycle; counters and FSM only advance when high.
- clear_i, input, 1: synchronous soft clear of state, counters and sticky flags.
- a_i, b_i, c_i, input, DATA_WIDTH: replica 0/1/2 words.
- winner_o, output, DATA_WIDTH: voted word (combinational).
- fault_o, output, 1: valid_i and any pairwise word mismatch this cycle (combinational).
- replica_err_o, output, 3: sticky per-replica condemned flags, bit i is replica i.
- mode_o, output, 2: current FSM state; 0=TMR, 1=DEGRADED, 2=FAILED.
- uncorrectable_o, output, 1: high while in FAILED (registered).
- fault_cnt_o, output, CNT_WIDTH: saturating count of cycles with fault_o high.

## Operation

- Odd-one-out per replica i, word-level: the other two replicas are equal and replica i differs. No-majority: all three pairwise differ.
- Per-replica consecutive counter cnt[i], width $clog2(THRESHOLD+1):
  - On a valid cycle, increments (saturating at THRESHOLD) when i is odd-one-out.
  - Resets to 0 when replica i equals the majority word.
  - Unchanged on a no-majority cycle or when valid_i is low.
- TMR state:
  - winner_o is the bitwise majority of a/b/c.
  - When cnt[i] reaches THRESHOLD on this valid cycle: set replica_err_o[i] and go to DEGRADED, excluding i.
  - A no-majority valid cycle goes to FAILED.
- DEGRADED state:
  - winner_o is the lower-indexed healthy replica.
  - A valid cycle on which the two healthy replicas differ goes to FAILED.
  - The condemned replica is ignored, and its counter is frozen.
- FAILED state:
  - winner_o is the bitwise majority of a/b/c (best effort).
  - uncorrectable_o stays 1.
  - Exit only via rst or clear_i.
- fault_cnt_o increments on each cycle with fault_o high and saturates at 2^CNT_WIDTH-1.
- clear_i returns the FSM to TMR and zeroes cnt[], replica_err_o and fault_cnt_o.
  - clear_i has priority over rst-free updates in the same cycle.
  - The sample on a clear cycle does not affect state or counters.
  - winner_o and fault_o remain combinational on a clear cycle.

## Timing

- Reset (rst=1 at a clock edge) sets mode_o=0, replica_err_o=0, uncorrectable_o=0, fault_cnt_o=0, cnt[]=0.
- winner_o and fault_o are combinational from the inputs and the registered mode; zero latency.
- State, counters, replica_err_o and uncorrectable_o update at the edge ending the triggering cycle and are visible the next cycle.
- On the threshold-hitting cycle, winner_o is still the TMR majority; the degraded selection applies from the next cycle.
- Reset mid-operation discards all history.
- With valid_i low, inputs are don't-care for state and fault_o=0; winner_o still reflects the mode's selection.
- If two counters could reach THRESHOLD in the same cycle (impossible by construction, since odd-one-out is exclusive), the lowest index wins.

## Configuration

- Macro CV32E40P_TMR_DEGRADE_EN.
- Defined: full behaviour above, including the DEGRADED state.
- Undefined:
  - The DEGRADED state is not built.
  - Reaching THRESHOLD still sets replica_err_o[i], but the FSM stays in TMR with bitwise majority.
  - cnt[i] keeps counting (saturated).
  - A no-majority cycle still goes to FAILED.
  - mode_o never reads 1.

## Test plan

- Reset then 10 valid cycles with a=b=c=0x1234_5678 -> winner_o=0x1234_5678, fault_o=0, mode_o=0, fault_cnt_o=0.
- b_i=0xFFFF_0000, a=c=0x0000_FFFF for 2 valid cycles, then one agreeing cycle, then 2 more mismatches -> cnt[1] resets, no degradation, fault_cnt_o=4.
- b_i odd-one-out for 3 consecutive valid cycles (THRESHOLD=3) -> after the 3rd edge, mode_o=1 and replica_err_o=3'b010. Next cycle, b_i=garbage with a=c=0xA5A5_A5A5 gives winner_o=0xA5A5_A5A5. With the macro undefined, mode_o stays 0.
- In DEGRADED excluding b: a=0x1, c=0x2, valid -> next cycle uncorrectable_o=1, mode_o=2. Assert clear_i -> next cycle mode_o=0, all flags and counters 0.
- a=0x1, b=0x2, c=0x4 valid in TMR -> winner_o=0x0 that cycle, then FAILED. valid_i=0 with mismatching inputs -> no counter change, fault_o=0.
- Hold fault_o high for 300 cycles with CNT_WIDTH=8 -> fault_cnt_o saturates at 255. Assert rst mid-stream -> all outputs return to reset values the next cycle.
